fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the fetch PC and issues in-order read requests to instruction memory, which may have variable response latency.
- Buffers returned instructions in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Handles branch redirects from the PC controller by flushing the FIFO and discarding in-flight responses.

---
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order imem requests, head-registered
// instruction FIFO, redirect flush with stale-response drain. Optional FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_inst,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flushed_insts
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      out_q, out_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [0:0]            state_q, state_d;
    logic [INST_WIDTH-1:0] head_inst_q, head_inst_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [INST_WIDTH-1:0] buf_inst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc   [FIFO_DEPTH];

    logic                  credit_ok;
    logic                  req_fire;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [CNT_W-1:0]      out_after_rsp;

    assign credit_ok      = ({1'b0, count_q} + {1'b0, out_q}) < {1'b0, DEPTH_C};
    assign imem_req_valid = !reset && (state_q == ST_RUN) && !halt && !redirect && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (count_q != '0);
    assign inst           = head_inst_q;
    assign inst_pc        = head_pc_q;
    assign pop            = inst_valid && inst_ready;
    assign push           = imem_rsp_valid && (state_q == ST_RUN) && !redirect;
    // In RUN every outstanding request is live and contiguous, so the oldest one
    // (the one responding now) sits 'outstanding' addresses behind fetch_pc.
    assign rsp_pc         = fetch_pc_q - ADDR_WIDTH'(out_q);
    assign out_after_rsp  = out_q - CNT_W'(imem_rsp_valid);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        out_d       = out_q;
        discard_d   = discard_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        state_d     = state_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_addr;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            out_d      = out_after_rsp;
            discard_d  = out_after_rsp;
            state_d    = (out_after_rsp != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
            end
            out_d = out_after_rsp + CNT_W'(req_fire);
            if ((state_q == ST_DRAIN) && imem_rsp_valid) begin
                discard_d = discard_q - ONE_C;
                if (discard_q == ONE_C) begin
                    state_d = ST_RUN;
                end
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            // Head register: next stored entry if one remains, else bypass the push.
            if (pop && (count_q > ONE_C)) begin
                head_inst_d = buf_inst[rd_ptr_d];
                head_pc_d   = buf_pc[rd_ptr_d];
            end else if (push && ((count_q - CNT_W'(pop)) == '0)) begin
                head_inst_d = imem_rsp_inst;
                head_pc_d   = rsp_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= ADDR_WIDTH'(RESET_PC);
            out_q       <= '0;
            discard_q   <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            state_q     <= ST_RUN;
            head_inst_q <= '0;
            head_pc_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            out_q       <= out_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            state_q     <= state_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr_q] <= imem_rsp_inst;
            buf_pc[wr_ptr_q]   <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0]    stall_q, stall_d;
    logic [15:0]    flushed_q, flushed_d;
    logic [CNT_W:0] flush_add;
    logic [16:0]    flush_sum;

    always_comb begin
        flush_add = '0;
        if (redirect) begin
            flush_add = {1'b0, count_q - CNT_W'(pop)} + (CNT_W+1)'(imem_rsp_valid);
        end else if ((state_q == ST_DRAIN) && imem_rsp_valid) begin
            flush_add = (CNT_W+1)'(1);
        end
        flush_sum = {1'b0, flushed_q} + 17'(flush_add);
        flushed_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        stall_d   = stall_q;
        if (!inst_valid && (state_q == ST_RUN) && !halt && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign flushed_insts = flushed_q;
`endif

endmodule
